// File: rtl/fb_pkg.sv
// Shared constants and types for the framebuffer scan-out arbiter.
package fb_pkg;

   localparam int unsigned FB_W        = 160;
   localparam int unsigned FB_H        = 120;
   localparam int unsigned SCALE_SHIFT = 2;
   localparam int unsigned FB_AW       = 15;
   localparam int unsigned H_ACTIVE    = 640;
   localparam int unsigned H_TOTAL     = 800;
   localparam int unsigned V_ACTIVE    = 480;
   localparam int unsigned V_TOTAL     = 525;
   localparam int unsigned FETCH_START = 640;

   typedef enum logic [1:0] {IDLE, FETCH, DRAIN} fetch_state_t;

   typedef logic [7:0] pixel_t;

endpackage

// File: rtl/fb_scan_arbiter_if.sv
// Write-requester and framebuffer-memory bus; master is the arbiter side.
interface fb_scan_arbiter_if;
   import fb_pkg::*;

   logic             wr_req;
   logic [FB_AW-1:0] wr_addr;
   pixel_t           wr_data;
   logic             wr_ack;
   logic [FB_AW-1:0] mem_addr;
   logic             mem_we;
   pixel_t           mem_wdata;
   pixel_t           mem_rdata;

   modport master (
      input  wr_req, wr_addr, wr_data, mem_rdata,
      output wr_ack, mem_addr, mem_we, mem_wdata
   );

   modport slave (
      output wr_req, wr_addr, wr_data, mem_rdata,
      input  wr_ack, mem_addr, mem_we, mem_wdata
   );

endinterface

// File: rtl/fb_scan_arbiter_line_buffer.sv
// Ping-pong line buffer: two banks, one write port, one registered read port
// whose output is zeroed by a registered valid.
module line_buffer
   import fb_pkg::*;
#(
   parameter int unsigned DEPTH = 160,
   parameter int unsigned IDX_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_en,
   input  logic             wr_bank,
   input  logic [IDX_W-1:0] wr_idx,
   input  pixel_t           wr_data,
   input  logic             rd_valid,
   input  logic             rd_bank,
   input  logic [IDX_W-1:0] rd_idx,
   output pixel_t           rd_data
);

   pixel_t mem [2][DEPTH];
   pixel_t rd_q, rd_d;
   logic   valid_q, valid_d;

   always_comb begin
      rd_d    = mem[rd_bank][rd_idx];
      valid_d = rd_valid;
   end

   // Storage and read register are not reset.
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_bank][wr_idx] <= wr_data;
      rd_q <= rd_d;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) valid_q <= 1'b0;
      else     valid_q <= valid_d;
   end

   always_comb begin
      rd_data = valid_q ? rd_q : '0;
   end

endmodule

// File: rtl/fb_scan_arbiter.sv
// Shares the single-port framebuffer between per-line prefetch into a
// ping-pong line buffer and a drawing-engine writer; drives the VGA pixel.
module fb_scan_arbiter
   import fb_pkg::*;
#(
   parameter int unsigned FB_W        = fb_pkg::FB_W,
   parameter int unsigned FB_H        = fb_pkg::FB_H,
   parameter int unsigned SCALE_SHIFT = fb_pkg::SCALE_SHIFT
) (
   input  logic                 vgaclk,
   input  logic                 rst,
   input  logic [9:0]           hc,
   input  logic [9:0]           vc,
   fb_scan_arbiter_if.master    bus,
   output pixel_t               pix_out,
   output logic                 fetch_busy
);

   localparam int unsigned IDX_W        = $clog2(FB_W);
   localparam logic [9:0]  H_LAST       = 10'(H_TOTAL - 1);
   localparam logic [9:0]  V_LAST       = 10'(V_TOTAL - 1);
   localparam logic [9:0]  V_LAST_FETCH = 10'((FB_H << SCALE_SHIFT) - 1);

   fetch_state_t     state_q, state_d;
   logic [IDX_W-1:0] col_q, col_d;
   logic [FB_AW-1:0] fetch_addr_q, fetch_addr_d;
   logic             bank_q, bank_d;
   logic             lb_we_q, lb_we_d;
   logic [IDX_W-1:0] lb_idx_q, lb_idx_d;
   logic [9:0]       nhc, nvc;
   logic             win, start, tgt_bank, disp_valid;

   always_comb begin
      nhc = (hc == H_LAST) ? '0 : hc + 10'd1;
      nvc = vc;
      if (hc == H_LAST) nvc = (vc == V_LAST) ? '0 : vc + 10'd1;
      win = ((vc[SCALE_SHIFT-1:0] == '1) && (vc < V_LAST_FETCH)) || (vc == V_LAST);
      // Bit 0 of (vc>>SCALE_SHIFT)+1 is the inverse of vc[SCALE_SHIFT].
      tgt_bank   = (vc == V_LAST) ? 1'b0 : ~vc[SCALE_SHIFT];
      // Entry is decided one cycle early so the reads occupy hc 640..799.
      start      = (state_q == IDLE) && (nhc == 10'(FETCH_START)) && win;
      disp_valid = (nhc < 10'(H_ACTIVE)) && (nvc < 10'(V_ACTIVE));
   end

   always_comb begin
      state_d       = state_q;
      col_d         = col_q;
      fetch_addr_d  = fetch_addr_q;
      bank_d        = bank_q;
      lb_we_d       = (state_q == FETCH);
      lb_idx_d      = col_q;
      bus.mem_addr  = '0;
      bus.mem_we    = 1'b0;
      bus.mem_wdata = '0;
      bus.wr_ack    = 1'b0;
      fetch_busy    = (state_q != IDLE);

      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = FETCH;
               col_d   = '0;
               bank_d  = tgt_bank;
               if (vc == V_LAST) fetch_addr_d = '0;
            end
         end
         FETCH: begin
            bus.mem_addr = fetch_addr_q;
            fetch_addr_d = fetch_addr_q + FB_AW'(1);
            if (col_q == IDX_W'(FB_W - 1)) state_d = DRAIN;
            else                            col_d   = col_q + IDX_W'(1);
         end
         DRAIN:   state_d = IDLE;
         default: state_d = IDLE;
      endcase

      if ((state_q != FETCH) && bus.wr_req) begin
         bus.mem_we    = 1'b1;
         bus.mem_addr  = bus.wr_addr;
         bus.mem_wdata = bus.wr_data;
         bus.wr_ack    = 1'b1;
      end
   end

   always_ff @(posedge vgaclk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         col_q        <= '0;
         fetch_addr_q <= '0;
         bank_q       <= 1'b0;
         lb_we_q      <= 1'b0;
         lb_idx_q     <= '0;
      end else begin
         state_q      <= state_d;
         col_q        <= col_d;
         fetch_addr_q <= fetch_addr_d;
         bank_q       <= bank_d;
         lb_we_q      <= lb_we_d;
         lb_idx_q     <= lb_idx_d;
      end
   end

   line_buffer #(
      .DEPTH (FB_W),
      .IDX_W (IDX_W)
   ) u_line_buffer (
      .clk      (vgaclk),
      .rst      (rst),
      .wr_en    (lb_we_q),
      .wr_bank  (bank_q),
      .wr_idx   (lb_idx_q),
      .wr_data  (bus.mem_rdata),
      .rd_valid (disp_valid),
      .rd_bank  (nvc[SCALE_SHIFT]),
      .rd_idx   (IDX_W'(nhc >> SCALE_SHIFT)),
      .rd_data  (pix_out)
   );

endmodule
